arb16_rr_disp: RTL and testbench
================================

// Module: arb16_rr_disp
// PURPOSE
//  Round-robin arbiter for 16 active-low requesters, grouped 15..8 / 7..0 as in the dual-74148 encoder path.
//  Grants one requester at a time for a bounded hold window.
//  Reports the granted index with 74148-style GS_N/EO_N flags.
//  Drives a 2-digit multiplexed 4511-style seven-segment display of the last granted index (decimal 0-15).
//  Replaces the fixed-priority encoder wherever a shared resource needs fair access.
// PARAMETERS
//  HOLD_CYCLES  8  max grant length in clk cycles (>=1)
//  SCAN_DIV     4  clk cycles per display digit slot (>=1)
// PORTS
//  clk       in   1   single clock, all state on rising edge
//  rst       in   1   synchronous reset, active-high
//  in_15_8   in   8   requests 15..8, active-low (bit7 = req15)
//  in_7_0    in   8   requests 7..0, active-low (bit7 = req7)
//  done      in   1   granted requester finished; ends grant early (ignored unless GRANT)
//  gnt_n     out  16  one-cold grant, bit i low = requester i granted
//  gnt_idx   out  4   index of current/last grant
//  GS_N      out  1   low while a grant is active
//  EO_N      out  1   low when in IDLE and all 16 requests high (no request pending)
//  Seg       out  8   segments, active-high: [0]=a..[6]=g, [7]=dp (always 0)
//  Dig       out  2   digit select, active-high one-hot: 01 = units, 10 = tens
// BEHAVIOUR
//  Reset values (rst high at an edge; takes effect that edge, also mid-grant):
//   state=IDLE, gnt_n=16'hFFFF, gnt_idx=0, GS_N=1, EO_N=1, last=15, valid=0,
//   hold cnt=0, scan cnt=0, Dig=01, Seg=0.
//  req[i] = ~{in_15_8,in_7_0}[i]. All outputs are registered.
//  FSM states: IDLE, GRANT, RELEASE.
//  IDLE:
//   - If any req is set: winner = first set index searching last+1, last+2, ... mod 16
//     (wrap 15->0). After reset the search starts at index 0.
//   - Next edge: GRANT, gnt_n[winner]=0, gnt_idx=winner, GS_N=0, cnt=HOLD_CYCLES-1, valid=1.
//   - Grant is visible 1 cycle after the request is sampled.
//   - If no req: stay IDLE; EO_N=0 next edge, else EO_N=1.
//  GRANT:
//   - Leave when any of: cnt==0, done==1, req[gnt_idx]==0 (requester dropped).
//   - Coincident end conditions cause a single exit.
//   - Otherwise cnt decrements each cycle.
//   - A grant therefore lasts at most HOLD_CYCLES cycles.
//   - Exit edge: RELEASE, gnt_n=FFFF, GS_N=1, last=gnt_idx. EO_N is held 1 throughout GRANT.
//  RELEASE:
//   - Exactly one dead cycle (no grant), then IDLE unconditionally.
//   - Requests seen here are arbitrated in the following IDLE cycle.
//   - Grant-to-grant gap is therefore 2 cycles.
//  Other requests changing during GRANT never alter gnt_idx.
//  gnt_idx holds its value through RELEASE/IDLE until the next grant.
//  Display:
//   - Scan counter wraps every SCAN_DIV cycles; Dig toggles 01<->10 at each wrap.
//   - Seg shows the digit for the Dig value latched that cycle.
//   - units digit = gnt_idx mod 10; tens = 1 if gnt_idx>=10, else blank (Seg=0).
//   - valid=0 (no grant since reset): both digits blank.
//   - 4511 patterns (gfedcba):
//     0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
// TESTING
//  1. rst, all inputs FF/FF, 20 clks -> gnt_n=FFFF, GS_N=1, EO_N=0, Seg=00 both digits.
//  2. in_7_0=FE (req0) held -> gnt_n=FFFE 1 clk later, GS_N=0.
//     Grant lasts 8 clks, 1 RELEASE clk, then re-granted to 0; units Seg=3F.
//  3. req3,req12 both held -> grants alternate 3,12,3,12.
//     While idx=12: Dig=10 Seg=06, Dig=01 Seg=5B.
//  4. Grant to 5, pulse done on 3rd grant cycle -> GS_N=1 next edge, RELEASE, then next winner from 6 upward.
//  5. Grant to 15, only req0 and req15 pending -> next grant is 0 (wrap).
//     Requester 15 releasing its input mid-grant ends that grant.
//  6. rst asserted mid-GRANT -> next edge gnt_n=FFFF, GS_N=1, Seg=00.
//     With req0,req9 held, the first grant after reset is 0.

Source files
------------

// File: rtl/arb16_rr_disp.sv
// Round-robin arbiter for 16 active-low requesters with 74148-style flags
// and a 2-digit multiplexed seven-segment readout of the last granted index.
module arb16_rr_disp #(
    parameter int HOLD_CYCLES = 8,
    parameter int SCAN_DIV    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_15_8,
    input  logic [7:0]  in_7_0,
    input  logic        done,
    output logic [15:0] gnt_n,
    output logic [3:0]  gnt_idx,
    output logic        GS_N,
    output logic        EO_N,
    output logic [7:0]  Seg,
    output logic [1:0]  Dig
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t         state;
    logic [15:0]    req;
    logic [3:0]     last;
    logic           valid;
    logic [HW-1:0]  hold_cnt;
    logic [SW-1:0]  scan_cnt;

    logic [3:0]     winner;
    logic [3:0]     cand;
    logic           any_req;
    logic           grant_end;
    logic           scan_wrap;
    logic [1:0]     dig_nxt;
    logic [3:0]     units;
    logic [7:0]     seg_nxt;

    assign req     = ~{in_15_8, in_7_0};
    assign any_req = |req;

    // Walk from farthest to nearest so the first set index after 'last' wins;
    // k=16 revisits 'last' itself as the lowest-priority candidate.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = 16; k >= 1; k--) begin
            cand = last + 4'(k);
            if (req[cand])
                winner = cand;
        end
    end

    assign grant_end = (hold_cnt == '0) || done || !req[gnt_idx];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
    assign dig_nxt   = scan_wrap ? {Dig[0], Dig[1]} : Dig;
    assign units     = (gnt_idx >= 4'd10) ? gnt_idx - 4'd10 : gnt_idx;

    // Segment data is produced for the digit being selected on the same edge.
    always_comb begin
        seg_nxt = '0;
        if (valid) begin
            if (dig_nxt[1])
                seg_nxt = (gnt_idx >= 4'd10) ? {1'b0, seg7(4'd1)} : 8'h00;
            else
                seg_nxt = {1'b0, seg7(units)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_n    <= 16'hFFFF;
            gnt_idx  <= '0;
            GS_N     <= 1'b1;
            EO_N     <= 1'b1;
            last     <= 4'd15;
            valid    <= 1'b0;
            hold_cnt <= '0;
            scan_cnt <= '0;
            Dig      <= 2'b01;
            Seg      <= '0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            Dig      <= dig_nxt;
            Seg      <= seg_nxt;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= GRANT;
                        gnt_n    <= ~(16'h1 << winner);
                        gnt_idx  <= winner;
                        GS_N     <= 1'b0;
                        EO_N     <= 1'b1;
                        hold_cnt <= HW'(HOLD_CYCLES - 1);
                        valid    <= 1'b1;
                    end else begin
                        EO_N     <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state <= RELEASE;
                        gnt_n <= 16'hFFFF;
                        GS_N  <= 1'b1;
                        last  <= gnt_idx;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb16_rr_disp.sv
// Bench for arb16_rr_disp: directed scenarios plus random traffic, every cycle
// compared against a cycle-level behavioural model of the arbiter and display.
module tb_arb16_rr_disp;

    localparam int HOLD = 8;
    localparam int SCAN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_15_8 = 8'hFF;
    logic [7:0]  in_7_0  = 8'hFF;
    logic        done = 1'b0;
    logic [15:0] gnt_n;
    logic [3:0]  gnt_idx;
    logic        GS_N, EO_N;
    logic [7:0]  Seg;
    logic [1:0]  Dig;

    arb16_rr_disp #(.HOLD_CYCLES(HOLD), .SCAN_DIV(SCAN)) dut (
        .clk(clk), .rst(rst), .in_15_8(in_15_8), .in_7_0(in_7_0), .done(done),
        .gnt_n(gnt_n), .gnt_idx(gnt_idx), .GS_N(GS_N), .EO_N(EO_N),
        .Seg(Seg), .Dig(Dig)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: phase 0=idle 1=granted 2=dead cycle; age = cycles granted so far.
    int          m_phase = 0;
    int          m_age   = 0;
    int          m_last  = 15;
    int          m_idx   = 0;
    bit          m_valid = 0;
    logic        m_eo    = 1'b1;
    int          m_t     = 0;
    logic [7:0]  m_seg   = 8'h00;

    function automatic logic [1:0] dig_of(input int t);
        return (((t / SCAN) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] seg_of(input logic [1:0] dg, input int idx, input bit v);
        if (!v) return 8'h00;
        if (dg == 2'b10) return (idx >= 10) ? 8'h06 : 8'h00;
        case (idx % 10)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] r;
        int          w;
        r = ~{in_15_8, in_7_0};
        w = 0;
        if (rst) begin
            m_phase = 0; m_last = 15; m_idx = 0; m_valid = 0;
            m_eo = 1'b1; m_t = 0; m_seg = 8'h00;
        end else begin
            m_t++;
            m_seg = seg_of(dig_of(m_t), m_idx, m_valid);
            case (m_phase)
                0: begin
                    if (r != 16'h0) begin
                        for (int k = 1; k <= 16; k++) begin
                            if (r[(m_last + k) % 16]) begin
                                w = (m_last + k) % 16;
                                break;
                            end
                        end
                        m_phase = 1; m_idx = w; m_valid = 1; m_age = 1; m_eo = 1'b1;
                    end else begin
                        m_eo = 1'b0;
                    end
                end
                1: begin
                    if (m_age >= HOLD || done || !r[m_idx]) begin
                        m_phase = 2; m_last = m_idx;
                    end else begin
                        m_age++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        check("gnt_n",   gnt_n, (m_phase == 1) ? ~(16'h1 << m_idx) : 16'hFFFF);
        check("gnt_idx", {12'h0, gnt_idx}, 16'(m_idx));
        check("GS_N",    {15'h0, GS_N}, {15'h0, (m_phase != 1)});
        check("EO_N",    {15'h0, EO_N}, {15'h0, m_eo});
        check("Dig",     {14'h0, Dig}, {14'h0, dig_of(m_t)});
        check("Seg",     {8'h0, Seg}, {8'h0, m_seg});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // 1: reset, then idle with nothing requested
        rst = 1'b1; ticks(2);
        rst = 1'b0; ticks(20);
        check("s1_eo",  {15'h0, EO_N}, 16'h0000);
        check("s1_gnt", gnt_n, 16'hFFFF);
        check("s1_seg", {8'h0, Seg}, 16'h0000);

        // 2: req0 held
        in_7_0 = 8'hFE; tick();
        check("s2_gnt", gnt_n, 16'hFFFE);
        check("s2_gs",  {15'h0, GS_N}, 16'h0000);
        ticks(7);
        check("s2_hold", gnt_n, 16'hFFFE);
        tick();
        check("s2_rel", gnt_n, 16'hFFFF);
        ticks(2);
        check("s2_regrant", gnt_n, 16'hFFFE);
        ticks(12);

        // 3: req3 and req12 alternate
        in_7_0 = 8'hF7; in_15_8 = 8'hEF;
        ticks(50);

        // 4: grant to 5, done on its 3rd cycle, next winner searched from 6
        in_7_0 = 8'hFF; in_15_8 = 8'hFF; ticks(4);
        in_7_0 = 8'hDF; tick();
        check("s4_idx", {12'h0, gnt_idx}, 16'd5);
        in_7_0 = 8'hDB; in_15_8 = 8'hFD; ticks(2);
        done = 1'b1; tick();
        done = 1'b0;
        check("s4_gs", {15'h0, GS_N}, 16'h0001);
        ticks(2);
        check("s4_next", {12'h0, gnt_idx}, 16'd9);
        ticks(10);

        // 5: wrap from 15 to 0, then 15 drops its request mid-grant
        in_7_0 = 8'hFF; in_15_8 = 8'hFF; ticks(4);
        in_15_8 = 8'h7F; tick();
        check("s5_idx15", {12'h0, gnt_idx}, 16'd15);
        in_7_0 = 8'hFE;
        for (int i = 0; i < 40 && !(m_phase == 1 && m_idx != 15); i++) tick();
        check("s5_wrap", {12'h0, gnt_idx}, 16'd0);
        for (int i = 0; i < 40 && !(m_phase == 1 && m_idx == 15); i++) tick();
        ticks(2);
        in_15_8 = 8'hFF; tick();
        check("s5_drop", {15'h0, GS_N}, 16'h0001);
        ticks(6);

        // 6: reset mid-grant, then req0/req9 -> 0 first
        in_7_0 = 8'hFE; in_15_8 = 8'hFD;
        for (int i = 0; i < 40 && !(m_phase == 1 && m_idx == 9); i++) tick();
        ticks(2);
        rst = 1'b1; tick();
        check("s6_gnt", gnt_n, 16'hFFFF);
        check("s6_seg", {8'h0, Seg}, 16'h0000);
        rst = 1'b0; tick();
        check("s6_first", gnt_n, 16'hFFFE);
        ticks(30);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                logic [15:0] r;
                r = 16'($urandom & $urandom & $urandom);
                {in_15_8, in_7_0} = ~r;
            end
            done = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; done = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
